// File: rtl/axis_traffic_gen.sv
// axis_traffic_gen: per-node AXI-Stream packet injector for the mesh NoC.
// A start pulse launches a burst of fixed-length packets to a fixed or rotating
// destination, with a programmable idle gap between packets.
// Header  (beat 0): [31:24] SRC_ID, [23:16] effective length, [15:0] seq.
// Payload (beat k): [31:16] seq, [15:0] k.
// Optional macro TGEN_STALL_STATS_EN adds the stall_cycles output and counter.
module axis_traffic_gen #(
  parameter int unsigned TDATA_WIDTH = 32,
  parameter int unsigned TDEST_WIDTH = 4,
  parameter int unsigned NUM_NODES   = 4,
  parameter int unsigned SRC_ID      = 0,
  parameter int unsigned LEN_WIDTH   = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cfg_start,
  input  logic [15:0]            cfg_num_pkts,
  input  logic [LEN_WIDTH-1:0]   cfg_pkt_len,
  input  logic                   cfg_rotate,
  input  logic [TDEST_WIDTH-1:0] cfg_dest,
  input  logic [7:0]             cfg_gap,
  output logic                   busy,
  output logic                   done,
  output logic [15:0]            pkts_sent,
`ifdef TGEN_STALL_STATS_EN
  output logic [31:0]            stall_cycles,
`endif
  output logic                   axis_out_tvalid,
  input  logic                   axis_out_tready,
  output logic [TDATA_WIDTH-1:0] axis_out_tdata,
  output logic                   axis_out_tlast,
  output logic [TDEST_WIDTH-1:0] axis_out_tdest
);

  localparam int unsigned SEQ_W   = 16;
  localparam int unsigned GAP_W   = 8;
  localparam int unsigned STALL_W = 32;
  localparam int unsigned SUM_W   = SEQ_W + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_GAP  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e state_q, state_d;

  // Captured configuration
  logic [SEQ_W-1:0]       num_pkts_q, num_pkts_d;
  logic [LEN_WIDTH-1:0]   len_q, len_d;
  logic                   rotate_q, rotate_d;
  logic [TDEST_WIDTH-1:0] dest_q, dest_d;
  logic [GAP_W-1:0]       gap_q, gap_d;

  // Progress counters
  logic [SEQ_W-1:0]       seq_q, seq_d;
  logic [LEN_WIDTH-1:0]   beat_q, beat_d;
  logic [GAP_W-1:0]       gap_cnt_q, gap_cnt_d;
  logic [SEQ_W-1:0]       pkts_sent_q, pkts_sent_d;

  // Registered outputs
  logic                   tvalid_q, tvalid_d;
  logic [TDATA_WIDTH-1:0] tdata_q, tdata_d;
  logic                   tlast_q, tlast_d;
  logic [TDEST_WIDTH-1:0] tdest_q, tdest_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic [STALL_W-1:0]     stall_q, stall_d;

  logic                   start_acc_c;
  logic                   hs_c;
  logic                   last_hs_c;
  logic [SEQ_W-1:0]       seq_inc_c;
  logic [LEN_WIDTH-1:0]   beat_inc_c;

  // Zero-length packets are sent as a single header beat.
  function automatic logic [LEN_WIDTH-1:0] eff_len(input logic [LEN_WIDTH-1:0] l);
    return (l == '0) ? LEN_WIDTH'(1) : l;
  endfunction

  // Destination of the packet with sequence number s.
  function automatic logic [TDEST_WIDTH-1:0] calc_dest(input logic rot,
                                                       input logic [TDEST_WIDTH-1:0] base,
                                                       input logic [SEQ_W-1:0] s);
    logic [SUM_W-1:0] sum;
    sum = SUM_W'(base) + SUM_W'(s);
    if (rot) return TDEST_WIDTH'(sum % SUM_W'(NUM_NODES));
    else     return base;
  endfunction

  // Handshake and counter increment helpers
  always_comb begin
    start_acc_c = cfg_start && ((state_q == S_IDLE) || (state_q == S_DONE));
    hs_c        = tvalid_q && axis_out_tready;
    last_hs_c   = hs_c && tlast_q;
    seq_inc_c   = seq_q + SEQ_W'(1);
    beat_inc_c  = beat_q + LEN_WIDTH'(1);
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_acc_c) state_d = (cfg_num_pkts == '0) ? S_DONE : S_SEND;
      end
      S_SEND: begin
        if (last_hs_c) begin
          if (seq_inc_c == num_pkts_q) state_d = S_DONE;
          else if (gap_q != '0)        state_d = S_GAP;
        end
      end
      S_GAP: begin
        if (gap_cnt_q <= GAP_W'(1)) state_d = S_SEND;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath and output next values
  always_comb begin
    logic                   load_hdr;
    logic [SEQ_W-1:0]       hdr_seq;
    logic [LEN_WIDTH-1:0]   hdr_len;
    logic                   hdr_rot;
    logic [TDEST_WIDTH-1:0] hdr_base;

    num_pkts_d  = num_pkts_q;
    len_d       = len_q;
    rotate_d    = rotate_q;
    dest_d      = dest_q;
    gap_d       = gap_q;
    seq_d       = seq_q;
    beat_d      = beat_q;
    gap_cnt_d   = gap_cnt_q;
    pkts_sent_d = pkts_sent_q;
    tvalid_d    = tvalid_q;
    tdata_d     = tdata_q;
    tlast_d     = tlast_q;
    tdest_d     = tdest_q;
    stall_d     = stall_q;
    busy_d      = (state_d == S_SEND) || (state_d == S_GAP);
    done_d      = (state_d == S_DONE);

    load_hdr = 1'b0;
    hdr_seq  = seq_q;
    hdr_len  = len_q;
    hdr_rot  = rotate_q;
    hdr_base = dest_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_acc_c) begin
          num_pkts_d  = cfg_num_pkts;
          len_d       = eff_len(cfg_pkt_len);
          rotate_d    = cfg_rotate;
          dest_d      = cfg_dest;
          gap_d       = cfg_gap;
          seq_d       = '0;
          beat_d      = '0;
          gap_cnt_d   = '0;
          pkts_sent_d = '0;
          stall_d     = '0;
          tvalid_d    = 1'b0;
          if (state_d == S_SEND) begin
            load_hdr = 1'b1;
            hdr_seq  = '0;
            hdr_len  = eff_len(cfg_pkt_len);
            hdr_rot  = cfg_rotate;
            hdr_base = cfg_dest;
          end
        end
      end
      S_SEND: begin
        if (tvalid_q && !axis_out_tready && (stall_q != '1)) stall_d = stall_q + STALL_W'(1);
        if (hs_c) begin
          if (tlast_q) begin
            seq_d       = seq_inc_c;
            pkts_sent_d = pkts_sent_q + SEQ_W'(1);
            tvalid_d    = 1'b0;
            if (state_d == S_SEND) begin
              load_hdr = 1'b1;
              hdr_seq  = seq_inc_c;
            end else if (state_d == S_GAP) begin
              gap_cnt_d = gap_q;
            end
          end else begin
            beat_d  = beat_inc_c;
            tdata_d = TDATA_WIDTH'({seq_q, 16'(beat_inc_c)});
            tlast_d = (beat_inc_c == (len_q - LEN_WIDTH'(1)));
          end
        end
      end
      S_GAP: begin
        gap_cnt_d = gap_cnt_q - GAP_W'(1);
        if (state_d == S_SEND) load_hdr = 1'b1;
      end
      default: ;
    endcase

    if (load_hdr) begin
      beat_d   = '0;
      tvalid_d = 1'b1;
      tdata_d  = TDATA_WIDTH'({8'(SRC_ID), 8'(hdr_len), hdr_seq});
      tlast_d  = (hdr_len == LEN_WIDTH'(1));
      tdest_d  = calc_dest(hdr_rot, hdr_base, hdr_seq);
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      num_pkts_q  <= '0;
      len_q       <= '0;
      rotate_q    <= 1'b0;
      dest_q      <= '0;
      gap_q       <= '0;
      seq_q       <= '0;
      beat_q      <= '0;
      gap_cnt_q   <= '0;
      pkts_sent_q <= '0;
      tvalid_q    <= 1'b0;
      tdata_q     <= '0;
      tlast_q     <= 1'b0;
      tdest_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      stall_q     <= '0;
    end else begin
      num_pkts_q  <= num_pkts_d;
      len_q       <= len_d;
      rotate_q    <= rotate_d;
      dest_q      <= dest_d;
      gap_q       <= gap_d;
      seq_q       <= seq_d;
      beat_q      <= beat_d;
      gap_cnt_q   <= gap_cnt_d;
      pkts_sent_q <= pkts_sent_d;
      tvalid_q    <= tvalid_d;
      tdata_q     <= tdata_d;
      tlast_q     <= tlast_d;
      tdest_q     <= tdest_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      stall_q     <= stall_d;
    end
  end

  assign busy            = busy_q;
  assign done            = done_q;
  assign pkts_sent       = pkts_sent_q;
  assign axis_out_tvalid = tvalid_q;
  assign axis_out_tdata  = tdata_q;
  assign axis_out_tlast  = tlast_q;
  assign axis_out_tdest  = tdest_q;

`ifdef TGEN_STALL_STATS_EN
  assign stall_cycles = stall_q;
`else
  // Stall counter has no consumer without the statistics port.
  logic unused_stall;
  assign unused_stall = ^stall_q;
`endif

endmodule

// File: tb/tb_axis_traffic_gen.sv
// Scoreboard bench for axis_traffic_gen: directed bursts push expected beats,
// a negedge monitor pops and compares every handshaked beat.
module tb_axis_traffic_gen;

  logic        clk;
  logic        rst_n;
  logic        cfg_start;
  logic [15:0] cfg_num_pkts;
  logic [7:0]  cfg_pkt_len;
  logic        cfg_rotate;
  logic [3:0]  cfg_dest;
  logic [7:0]  cfg_gap;
  logic        busy;
  logic        done;
  logic [15:0] pkts_sent;
  logic        tvalid;
  logic        tready;
  logic [31:0] tdata;
  logic        tlast;
  logic [3:0]  tdest;
`ifdef TGEN_STALL_STATS_EN
  logic [31:0] stall_cycles;
`endif

  axis_traffic_gen dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .cfg_start       (cfg_start),
    .cfg_num_pkts    (cfg_num_pkts),
    .cfg_pkt_len     (cfg_pkt_len),
    .cfg_rotate      (cfg_rotate),
    .cfg_dest        (cfg_dest),
    .cfg_gap         (cfg_gap),
    .busy            (busy),
    .done            (done),
    .pkts_sent       (pkts_sent),
`ifdef TGEN_STALL_STATS_EN
    .stall_cycles    (stall_cycles),
`endif
    .axis_out_tvalid (tvalid),
    .axis_out_tready (tready),
    .axis_out_tdata  (tdata),
    .axis_out_tlast  (tlast),
    .axis_out_tdest  (tdest)
  );

  typedef struct packed {
    logic [31:0] data;
    logic        last;
    logic [3:0]  dest;
  } beat_t;

  beat_t exp_q[$];
  int    errors = 0;
  int    checks = 0;
  int    cyc = 0;
  int    gap_low = 0;
  int    valid_cnt = 0;
  int    last_hs_cyc = 0;
  logic  prev_stall = 1'b0;
  beat_t held;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected beats of one packet
  task automatic push_pkt(input logic [15:0] seq, input int len, input logic [3:0] dest);
    beat_t b;
    for (int k = 0; k < len; k++) begin
      b.data = (k == 0) ? {8'h00, 8'(len), seq} : {seq, 16'(k)};
      b.last = (k == len - 1);
      b.dest = dest;
      exp_q.push_back(b);
    end
  endtask

  // Monitor: handshake scoreboard, stall stability, gap accounting
  always @(negedge clk) begin
    beat_t e;
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (busy && !tvalid) gap_low++;
      if (tvalid) valid_cnt++;
      if (prev_stall) begin
        check("stall_valid", 32'(tvalid), 32'd1);
        check("stall_data", tdata, held.data);
        check("stall_last_dest", {27'd0, tlast, tdest}, {27'd0, held.last, held.dest});
      end
      if (tvalid && tready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", tdata, 32'hDEADBEEF);
        end else begin
          e = exp_q.pop_front();
          check("tdata", tdata, e.data);
          check("tlast", 32'(tlast), 32'(e.last));
          check("tdest", 32'(tdest), 32'(e.dest));
          if (tlast) last_hs_cyc = cyc;
        end
      end
      prev_stall = tvalid && !tready;
      held = '{data: tdata, last: tlast, dest: tdest};
    end
  end

  // Pulse start, then scramble cfg inputs to prove they were captured.
  task automatic do_start(input int num, input int len, input logic rot,
                          input logic [3:0] dest, input int gap);
    cfg_num_pkts = 16'(num);
    cfg_pkt_len  = 8'(len);
    cfg_rotate   = rot;
    cfg_dest     = dest;
    cfg_gap      = 8'(gap);
    cfg_start    = 1'b1;
    @(posedge clk);
    #1;
    cfg_start    = 1'b0;
    cfg_num_pkts = 16'd99;
    cfg_pkt_len  = 8'd7;
    cfg_rotate   = ~rot;
    cfg_dest     = 4'hF;
    cfg_gap      = 8'd3;
  endtask

  task automatic wait_done(input int exp_pkts, input bit chk_lat);
    bit got = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (done) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      check("done_timeout", 32'(done), 32'd1);
    end else begin
      check("pkts_sent", 32'(pkts_sent), 32'(exp_pkts));
      check("done_tvalid_busy", {30'd0, tvalid, busy}, 32'd0);
      if (chk_lat) check("done_latency", 32'(cyc - last_hs_cyc), 32'd1);
    end
    check("queue_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int vc;
    rst_n = 1'b0;
    cfg_start = 1'b0;
    cfg_num_pkts = '0;
    cfg_pkt_len = '0;
    cfg_rotate = 1'b0;
    cfg_dest = '0;
    cfg_gap = '0;
    tready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tvalid", 32'(tvalid), 32'd0);
    check("rst_tdata", tdata, 32'd0);
    check("rst_flags", {27'd0, tlast, tdest}, 32'd0);
    check("rst_busy_done", {30'd0, busy, done}, 32'd0);
    check("rst_pkts_sent", 32'(pkts_sent), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Zero-packet start: done next cycle, no valid
    vc = valid_cnt;
    do_start(0, 2, 1'b0, 4'd1, 0);
    @(negedge clk);
    check("zero_done", 32'(done), 32'd1);
    repeat (3) @(negedge clk);
    check("zero_no_valid", 32'(valid_cnt - vc), 32'd0);
    check("zero_pkts_sent", 32'(pkts_sent), 32'd0);

    // Back-to-back two-beat packets, fixed dest 1
    gap_low = 0;
    for (int s = 0; s < 3; s++) push_pkt(16'(s), 2, 4'd1);
    do_start(3, 2, 1'b0, 4'd1, 0);
    wait_done(3, 1'b1);
    check("b2b_no_bubble", 32'(gap_low), 32'd0);

    // Single-beat packets, rotating dest from 3
    for (int s = 0; s < 4; s++) push_pkt(16'(s), 1, 4'((3 + s) % 4));
    do_start(4, 1, 1'b1, 4'd3, 0);
    wait_done(4, 1'b1);

    // Programmable gap of 5 idle cycles
    gap_low = 0;
    push_pkt(16'd0, 3, 4'd2);
    push_pkt(16'd1, 3, 4'd2);
    do_start(2, 3, 1'b0, 4'd2, 5);
    wait_done(2, 1'b1);
    check("gap_low_cycles", 32'(gap_low), 32'd5);

    // Four-cycle backpressure mid-payload
    push_pkt(16'd0, 4, 4'd6);
    do_start(1, 4, 1'b0, 4'd6, 0);
    @(posedge clk);
    #1;
    tready = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    tready = 1'b1;
    wait_done(1, 1'b1);
`ifdef TGEN_STALL_STATS_EN
    check("stall_cycles", stall_cycles, 32'd4);
`endif

    // Start while busy is ignored
    for (int s = 0; s < 10; s++) push_pkt(16'(s), 1, 4'd0);
    do_start(10, 1, 1'b0, 4'd0, 0);
    repeat (3) @(posedge clk);
    #1;
    cfg_num_pkts = 16'd3;
    cfg_pkt_len  = 8'd2;
    cfg_dest     = 4'd5;
    cfg_start    = 1'b1;
    @(posedge clk);
    #1;
    cfg_start    = 1'b0;
    wait_done(10, 1'b1);

    // Reset mid-packet, then restart from seq 0
    exp_q.push_back('{data: 32'h00040000, last: 1'b0, dest: 4'd0});
    do_start(2, 4, 1'b0, 4'd0, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_tvalid", 32'(tvalid), 32'd0);
    check("midrst_tdata", tdata, 32'd0);
    check("midrst_flags", {25'd0, tlast, tdest, busy, done}, 32'd0);
    check("midrst_pkts_sent", 32'(pkts_sent), 32'd0);
    check("midrst_queue", 32'(exp_q.size()), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    push_pkt(16'd0, 4, 4'd0);
    do_start(1, 4, 1'b0, 4'd0, 0);
    wait_done(1, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
